sensor_acq_sequencer: RTL and testbench
=======================================

# sensor_acq_sequencer

Control-plane sequencer that runs one sensor acquisition round for the AMDC timing path. When the carrier-derived trigger arrives, it issues start pulses to the enabled sensors (4 eddy-current, encoder, ADC) and waits for each one's done. It records per-sensor latency, enforces a programmable timeout and flags overruns. It sits between the trigger generator and the sensor interface IPs, and its `acq_done` pulse feeds the scheduler interrupt logic.

## Interface
Parameters:
- `N_SENS`, 6 — number of sensor channels (bit order: eddy0..3, encoder, ADC)
- `CNT_W`, 32 — width of latency counter, timeout and time registers
- `OVR_W`, 16 — overrun counter width

Ports:
- `clk`  in  1  — single clock for all logic
- `rst`  in  1  — reset; synchronous, active-high
- `trigger`  in  1  — one-cycle start-of-round pulse
- `en_bits`  in  N_SENS  — channel enables, sampled at accepted trigger
- `timeout_cycles`  in  CNT_W  — round timeout in clk cycles, sampled at accepted trigger; 0 = disabled
- `done`  in  N_SENS  — per-sensor done, sampled as level while channel pending
- `ovr_clr`  in  1  — synchronous clear of `overrun_count`
- `time_sel`  in  3  — selects channel for `time_out`
- `start`  out  N_SENS  — per-sensor one-cycle start pulse (registered)
- `busy`  out  1  — round in progress
- `acq_done`  out  1  — one-cycle end-of-round pulse
- `timeout_flags`  out  N_SENS  — channels that timed out in last round
- `overrun_count`  out  OVR_W  — dropped triggers, saturating
- `time_out`  out  CNT_W  — latency of channel `time_sel`; 0 if `time_sel` ≥ N_SENS

## Operation
- FSM states: IDLE, START, WAIT, FINISH. Reset → IDLE.
- IDLE: `trigger` with `en_bits`≠0 → latch `en_q`, `to_q` → START. `trigger` with `en_bits`=0 → FINISH directly; no start pulses; times and flags unchanged.
- START (1 cycle):
  - `start = en_q`.
  - `pending <= en_q`, `cnt <= 1`, `timeout_flags <= 0`.
  - `done` ignored this cycle.
  - → WAIT.
- WAIT, each cycle:
  - For each i with `pending[i] & done[i]`: `time[i] <= cnt`, clear `pending[i]`.
  - If no bits remain pending after this cycle's dones → FINISH.
  - Else if `to_q`≠0 and `cnt == to_q`: `timeout_flags <= remaining pending`, `time[i] <= all-ones` for those channels → FINISH.
  - Else `cnt <= cnt+1`.
  - Counter saturates at all-ones; no wrap.
- FINISH (1 cycle): `acq_done`=1 → IDLE.
- Times of channels not enabled in a round keep their previous value.
- Overrun: `trigger` in START, WAIT or FINISH is dropped and `overrun_count` increments, saturating at 2^OVR_W−1. If `ovr_clr` and a dropped trigger occur in the same cycle, the clear wins and the count becomes 0.
- Simultaneous done and timeout on one channel: done wins; that channel records `cnt` with no flag.
- `rst` mid-round: FSM → IDLE next edge; all outputs and registers cleared; no `acq_done` for the aborted round.

## Timing
- Reset values:
  - `start`=0, `busy`=0, `acq_done`=0, `timeout_flags`=0, `overrun_count`=0.
  - All time registers 0, so `time_out`=0.
- Trigger accepted at cycle T:
  - START at T+1, with `start` high only at T+1.
  - WAIT cycle with `cnt`=k is T+1+k.
- Recorded latency k means done was sampled k cycles after the start pulse.
- Done at `cnt`=k ends the round: FINISH/`acq_done` at T+2+k; `busy` low from T+3+k.
- `busy` is high in START, WAIT and FINISH.
- Timeout at `cnt`=`to_q`: `acq_done` at T+2+`to_q`.
- Zero-enable trigger: `acq_done` at T+1, `busy` high at T+1 only.
- `time_out` is registered and reflects `time_sel` one cycle later.
- Minimum trigger spacing without overrun: round length + 1 cycle.

## Test plan
- `en_bits`=0x21, `timeout_cycles`=100, trigger at T; done[0] at T+6, done[5] at T+13:
  - start=0x21 at T+1 only; time0=5, time5=12; `acq_done` at T+14; flags=0; `busy` low at T+15.
- `en_bits`=0x03, `timeout_cycles`=20; done[0] at T+4, done[1] never:
  - `acq_done` at T+22; flags=0x02; time0=3, time1=0xFFFFFFFF.
- `en_bits`=0x10, `timeout_cycles`=8; done[4] first asserted at T+9 (`cnt`=8):
  - time4=8, flags=0, `acq_done` at T+10.
- `en_bits`=0x00 trigger:
  - start stays 0; `acq_done` and `busy` at T+1 only; previous times retained.
- Three triggers during one WAIT → `overrun_count`=3.
- Preload 0xFFFE, then two drops → 0xFFFF (saturated).
- `ovr_clr` coincident with a dropped trigger → `overrun_count`=0.
- `rst` in WAIT at `cnt`=5:
  - All outputs 0 next cycle; no `acq_done`.
  - A new trigger then runs a normal round with correct times.

Source files
------------

// File: rtl/sensor_acq_sequencer.sv
// One acquisition round: fan out start pulses to enabled sensors, time each done,
// enforce an optional timeout and count triggers that arrive while a round is running.
module sensor_acq_sequencer #(
  parameter int N_SENS = 6,
  parameter int CNT_W  = 32,
  parameter int OVR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [N_SENS-1:0] en_bits,
  input  logic [CNT_W-1:0]  timeout_cycles,
  input  logic [N_SENS-1:0] done,
  input  logic              ovr_clr,
  input  logic [2:0]        time_sel,
  output logic [N_SENS-1:0] start,
  output logic              busy,
  output logic              acq_done,
  output logic [N_SENS-1:0] timeout_flags,
  output logic [OVR_W-1:0]  overrun_count,
  output logic [CNT_W-1:0]  time_out
);

  typedef enum logic [1:0] {IDLE, START, WAIT, FINISH} state_t;

  state_t            state_q, state_d;
  logic [N_SENS-1:0] en_q, en_d;
  logic [N_SENS-1:0] pending_q, pending_d;
  logic [N_SENS-1:0] start_q, start_d;
  logic [N_SENS-1:0] flags_q, flags_d;
  logic [N_SENS-1:0] remaining;
  logic [CNT_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  time_out_q, time_out_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic [CNT_W-1:0]  time_q [N_SENS];
  logic [CNT_W-1:0]  time_d [N_SENS];
  logic              timeout_hit;

  // Channels still outstanding once this cycle's dones are applied; a done
  // arriving on the timeout cycle therefore beats the timeout.
  assign remaining   = pending_q & ~done;
  assign timeout_hit = (state_q == WAIT) && (remaining != '0) &&
                       (to_q != '0) && (cnt_q == to_q);

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    to_d      = to_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    start_d   = '0;
    flags_d   = flags_q;
    time_d    = time_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          if (en_bits != '0) begin
            en_d    = en_bits;
            to_d    = timeout_cycles;
            start_d = en_bits;
            state_d = START;
          end else begin
            state_d = FINISH;
          end
        end
      end
      START: begin
        pending_d = en_q;
        cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
        flags_d   = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        for (int i = 0; i < N_SENS; i++) begin
          if (pending_q[i] && done[i]) time_d[i] = cnt_q;
        end
        pending_d = remaining;
        if (remaining == '0) begin
          state_d = FINISH;
        end else if (timeout_hit) begin
          flags_d = remaining;
          for (int i = 0; i < N_SENS; i++) begin
            if (remaining[i]) time_d[i] = '1;
          end
          pending_d = '0;
          state_d   = FINISH;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Clear takes priority over a simultaneously dropped trigger.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_clr) begin
      ovr_d = '0;
    end else if (trigger && (state_q != IDLE) && (ovr_q != '1)) begin
      ovr_d = ovr_q + 1'b1;
    end
  end

  always_comb begin
    time_out_d = '0;
    for (int i = 0; i < N_SENS; i++) begin
      if (int'(time_sel) == i) time_out_d = time_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      en_q       <= '0;
      to_q       <= '0;
      pending_q  <= '0;
      cnt_q      <= '0;
      start_q    <= '0;
      flags_q    <= '0;
      ovr_q      <= '0;
      time_out_q <= '0;
      for (int i = 0; i < N_SENS; i++) time_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      to_q       <= to_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      flags_q    <= flags_d;
      ovr_q      <= ovr_d;
      time_out_q <= time_out_d;
      for (int i = 0; i < N_SENS; i++) time_q[i] <= time_d[i];
    end
  end

  assign start         = start_q;
  assign busy          = (state_q != IDLE);
  assign acq_done      = (state_q == FINISH);
  assign timeout_flags = flags_q;
  assign overrun_count = ovr_q;
  assign time_out      = time_out_q;

endmodule

// File: tb/tb_sensor_acq_sequencer.sv
// Directed bench for sensor_acq_sequencer: round timing, latencies, timeouts,
// overrun counting/saturation and mid-round reset.
module tb_sensor_acq_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [5:0]  en_bits = '0;
  logic [31:0] timeout_cycles = '0;
  logic [5:0]  done = '0;
  logic        ovr_clr = 1'b0;
  logic [2:0]  time_sel = '0;
  logic [5:0]  start;
  logic        busy;
  logic        acq_done;
  logic [5:0]  timeout_flags;
  logic [15:0] overrun_count;
  logic [31:0] time_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sensor_acq_sequencer dut (
    .clk(clk), .rst(rst), .trigger(trigger), .en_bits(en_bits),
    .timeout_cycles(timeout_cycles), .done(done), .ovr_clr(ovr_clr),
    .time_sel(time_sel), .start(start), .busy(busy), .acq_done(acq_done),
    .timeout_flags(timeout_flags), .overrun_count(overrun_count), .time_out(time_out)
  );

  // Cycle n begins 1 time unit after a rising edge; inputs set during cycle n
  // are sampled at the edge that ends it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_time(input logic [2:0] sel, output logic [31:0] v);
    time_sel = sel;
    tick;
    v = time_out;
  endtask

  int         d_cyc [6];
  logic [5:0] obs_start1, obs_start_other;
  logic       obs_busy1;
  int         acq_first, acq_count, busy_low;

  // Trigger at cycle 0, then observe cycles 1..ncyc; done[i] pulses at cycle d_cyc[i] (0 = never).
  task automatic run_round(input logic [5:0] en, input logic [31:0] to, input int ncyc);
    en_bits = en;
    timeout_cycles = to;
    trigger = 1'b1;
    tick;
    trigger = 1'b0;
    obs_start1 = start;
    obs_busy1 = busy;
    obs_start_other = '0;
    acq_first = -1;
    acq_count = 0;
    busy_low = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (c != 1) obs_start_other |= start;
      if (acq_done) begin
        acq_count++;
        if (acq_first < 0) acq_first = c;
      end
      if (!busy && busy_low < 0) busy_low = c;
      for (int i = 0; i < 6; i++) done[i] = (d_cyc[i] == c);
      tick;
    end
    done = '0;
  endtask

  task automatic clear_dcyc;
    for (int i = 0; i < 6; i++) d_cyc[i] = 0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    repeat (3) tick;
    n_tests++; if (start !== 6'h00) begin n_fail++; $display("FAIL reset_start got %h want 00", start); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (acq_done !== 1'b0) begin n_fail++; $display("FAIL reset_acq_done got %b want 0", acq_done); end
    n_tests++; if (timeout_flags !== 6'h00) begin n_fail++; $display("FAIL reset_flags got %h want 00", timeout_flags); end
    n_tests++; if (overrun_count !== 16'h0) begin n_fail++; $display("FAIL reset_ovr got %h want 0000", overrun_count); end
    rst = 1'b0;
    tick;
    for (int s = 0; s < 6; s++) begin
      read_time(3'(s), v);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_time%0d got %h want 0", s, v); end
    end
    $display("[TB] reset: outputs and times checked");
  endtask

  task automatic test_two_channel;
    logic [31:0] v;
    clear_dcyc();
    d_cyc[0] = 6;
    d_cyc[5] = 13;
    run_round(6'h21, 32'd100, 18);
    n_tests++; if (obs_start1 !== 6'h21) begin n_fail++; $display("FAIL t1_start got %h want 21", obs_start1); end
    n_tests++; if (obs_start_other !== 6'h00) begin n_fail++; $display("FAIL t1_start_extra got %h want 00", obs_start_other); end
    n_tests++; if (acq_first != 14) begin n_fail++; $display("FAIL t1_acq_cycle got %0d want 14", acq_first); end
    n_tests++; if (acq_count != 1) begin n_fail++; $display("FAIL t1_acq_count got %0d want 1", acq_count); end
    n_tests++; if (busy_low != 15) begin n_fail++; $display("FAIL t1_busy_low got %0d want 15", busy_low); end
    n_tests++; if (timeout_flags !== 6'h00) begin n_fail++; $display("FAIL t1_flags got %h want 00", timeout_flags); end
    read_time(3'd0, v);
    n_tests++; if (v !== 32'd5) begin n_fail++; $display("FAIL t1_time0 got %0d want 5", v); end
    read_time(3'd5, v);
    n_tests++; if (v !== 32'd12) begin n_fail++; $display("FAIL t1_time5 got %0d want 12", v); end
    $display("[TB] two-channel round: acq_done at T+%0d", acq_first);
  endtask

  task automatic test_timeout;
    logic [31:0] v;
    clear_dcyc();
    d_cyc[0] = 4;
    run_round(6'h03, 32'd20, 26);
    n_tests++; if (acq_first != 22) begin n_fail++; $display("FAIL t2_acq_cycle got %0d want 22", acq_first); end
    n_tests++; if (timeout_flags !== 6'h02) begin n_fail++; $display("FAIL t2_flags got %h want 02", timeout_flags); end
    read_time(3'd0, v);
    n_tests++; if (v !== 32'd3) begin n_fail++; $display("FAIL t2_time0 got %0d want 3", v); end
    read_time(3'd1, v);
    n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t2_time1 got %h want ffffffff", v); end
    read_time(3'd5, v);
    n_tests++; if (v !== 32'd12) begin n_fail++; $display("FAIL t2_time5_kept got %0d want 12", v); end
    read_time(3'd6, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL t2_sel6 got %h want 0", v); end
    $display("[TB] timeout round: acq_done at T+%0d flags %h", acq_first, timeout_flags);
  endtask

  task automatic test_zero_enable;
    logic [31:0] v;
    clear_dcyc();
    run_round(6'h00, 32'd5, 4);
    n_tests++; if ((obs_start1 | obs_start_other) !== 6'h00) begin n_fail++; $display("FAIL t0_start got %h want 00", obs_start1 | obs_start_other); end
    n_tests++; if (acq_first != 1 || acq_count != 1) begin n_fail++; $display("FAIL t0_acq got cycle %0d count %0d want cycle 1 count 1", acq_first, acq_count); end
    n_tests++; if (obs_busy1 !== 1'b1 || busy_low != 2) begin n_fail++; $display("FAIL t0_busy got busy1 %b low %0d want 1 and 2", obs_busy1, busy_low); end
    n_tests++; if (timeout_flags !== 6'h02) begin n_fail++; $display("FAIL t0_flags_kept got %h want 02", timeout_flags); end
    read_time(3'd0, v);
    n_tests++; if (v !== 32'd3) begin n_fail++; $display("FAIL t0_time0_kept got %0d want 3", v); end
    $display("[TB] zero-enable trigger: acq_done at T+%0d", acq_first);
  endtask

  task automatic test_done_at_timeout;
    logic [31:0] v;
    clear_dcyc();
    d_cyc[4] = 9;
    run_round(6'h10, 32'd8, 14);
    n_tests++; if (acq_first != 10) begin n_fail++; $display("FAIL t3_acq_cycle got %0d want 10", acq_first); end
    n_tests++; if (timeout_flags !== 6'h00) begin n_fail++; $display("FAIL t3_flags got %h want 00", timeout_flags); end
    read_time(3'd4, v);
    n_tests++; if (v !== 32'd8) begin n_fail++; $display("FAIL t3_time4 got %0d want 8", v); end
    $display("[TB] done on timeout cycle: time4 %0d", v);
  endtask

  task automatic test_overrun;
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    en_bits = 6'h01;
    timeout_cycles = 32'd0;
    trigger = 1'b1;
    tick;
    for (int c = 1; c <= 12; c++) begin
      trigger = (c == 3 || c == 5 || c == 7);
      done[0] = (c == 10);
      tick;
    end
    trigger = 1'b0;
    done = '0;
    n_tests++; if (overrun_count !== 16'd3) begin n_fail++; $display("FAIL ovr_three got %0d want 3", overrun_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_round_end got busy %b want 0", busy); end
    $display("[TB] overrun: three dropped triggers -> %0d", overrun_count);
  endtask

  task automatic test_ovr_saturate;
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    en_bits = 6'h01;
    timeout_cycles = 32'd0;
    trigger = 1'b1;
    tick;
    // Trigger held through 65534 cycles of START/WAIT: one drop per cycle.
    repeat (65534) tick;
    trigger = 1'b0;
    tick;
    n_tests++; if (overrun_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload got %h want fffe", overrun_count); end
    for (int k = 0; k < 3; k++) begin
      trigger = 1'b1;
      tick;
      trigger = 1'b0;
      tick;
    end
    n_tests++; if (overrun_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", overrun_count); end
    trigger = 1'b1;
    ovr_clr = 1'b1;
    tick;
    trigger = 1'b0;
    ovr_clr = 1'b0;
    n_tests++; if (overrun_count !== 16'h0) begin n_fail++; $display("FAIL clr_wins got %h want 0000", overrun_count); end
    trigger = 1'b1;
    tick;
    trigger = 1'b0;
    n_tests++; if (overrun_count !== 16'h1) begin n_fail++; $display("FAIL drop_after_clr got %h want 0001", overrun_count); end
    done[0] = 1'b1;
    tick;
    done = '0;
    repeat (3) tick;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_round_end got busy %b want 0", busy); end
    $display("[TB] overrun saturation and clear priority: count %0d", overrun_count);
  endtask

  task automatic test_mid_reset;
    logic [31:0] v;
    int acq_seen;
    en_bits = 6'h03;
    timeout_cycles = 32'd0;
    trigger = 1'b1;
    tick;
    for (int c = 1; c <= 5; c++) begin
      trigger = (c == 3);
      tick;
    end
    trigger = 1'b0;
    rst = 1'b1;  // cycle 6: WAIT with cnt=5
    tick;
    n_tests++; if (busy !== 1'b0 || start !== 6'h00 || acq_done !== 1'b0) begin n_fail++; $display("FAIL mrst_ctrl got busy %b start %h acq %b want 0 00 0", busy, start, acq_done); end
    n_tests++; if (overrun_count !== 16'h0 || timeout_flags !== 6'h00) begin n_fail++; $display("FAIL mrst_regs got ovr %h flags %h want 0 0", overrun_count, timeout_flags); end
    rst = 1'b0;
    acq_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (acq_done) acq_seen++;
      tick;
    end
    n_tests++; if (acq_seen != 0) begin n_fail++; $display("FAIL mrst_no_acq got %0d want 0", acq_seen); end
    read_time(3'd1, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL mrst_time1 got %h want 0", v); end
    clear_dcyc();
    d_cyc[2] = 7;
    run_round(6'h04, 32'd50, 10);
    n_tests++; if (acq_first != 8 || obs_start1 !== 6'h04) begin n_fail++; $display("FAIL mrst_new_round got acq %0d start %h want 8 04", acq_first, obs_start1); end
    read_time(3'd2, v);
    n_tests++; if (v !== 32'd6) begin n_fail++; $display("FAIL mrst_time2 got %0d want 6", v); end
    $display("[TB] mid-round reset then new round: time2 %0d", v);
  endtask

  initial begin
    test_reset();
    test_two_channel();
    test_timeout();
    test_zero_enable();
    test_done_at_timeout();
    test_overrun();
    test_ovr_saturate();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
